// File: rtl/psr_cond_unit.sv
// Processor status register with a shadow flag stack for interrupts and a
// 4-bit branch-condition evaluator behind a one-deep valid/ready output stage.
module psr_cond_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4:0]                    flags_in,
  input  logic                          flag_we,
  input  logic                          flag_save,
  input  logic                          flag_restore,
  input  logic                          eval_valid,
  input  logic [3:0]                    eval_cond,
  output logic                          eval_ready,
  output logic                          br_valid,
  output logic                          br_taken,
  input  logic                          br_ready,
  output logic [4:0]                    flags_out,
  output logic [$clog2(STACK_DEPTH):0]  stk_depth,
  output logic                          stk_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  logic [4:0]    r_psr;
  logic [4:0]    r_stack [STACK_DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_err;
  logic          r_brValid;
  logic          r_brTaken;

  logic          w_full;
  logic          w_empty;
  logic          w_doPush;
  logic          w_doPop;
  logic          w_stkFault;
  logic [AW-1:0] w_topIdx;
  logic [4:0]    w_top;
  logic [4:0]    w_evalFlags;
  logic          w_accept;
  logic          w_result;

  // Flags are packed {N,Z,F,L,C}.
  function automatic logic condTrue(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    fc = f[0];
    fl = f[1];
    ff = f[2];
    fz = f[3];
    fn = f[4];
    case (c)
      4'h0:    condTrue = fz;
      4'h1:    condTrue = !fz;
      4'h2:    condTrue = fc;
      4'h3:    condTrue = !fc;
      4'h4:    condTrue = fl;
      4'h5:    condTrue = !fl;
      4'h6:    condTrue = fn;
      4'h7:    condTrue = !fn;
      4'h8:    condTrue = ff;
      4'h9:    condTrue = !ff;
      4'hA:    condTrue = !fl && !fz;
      4'hB:    condTrue = fl || fz;
      4'hC:    condTrue = !fn && !fz;
      4'hD:    condTrue = fn || fz;
      4'hE:    condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  endfunction

  // A simultaneous save and restore is a conflict: neither happens.
  assign w_full      = (r_depth == DW'(STACK_DEPTH));
  assign w_empty     = (r_depth == '0);
  assign w_doPush    = flag_save && !flag_restore && !w_full;
  assign w_doPop     = flag_restore && !flag_save && !w_empty;
  assign w_stkFault  = (flag_save && flag_restore) ||
                       (flag_save && w_full) ||
                       (flag_restore && w_empty);
  assign w_topIdx    = AW'(r_depth - DW'(1));
  assign w_top       = r_stack[w_topIdx];
  assign w_evalFlags = flag_we ? flags_in : (w_doPop ? w_top : r_psr);
  assign w_result    = condTrue(eval_cond, w_evalFlags);
  assign eval_ready  = !r_brValid || br_ready;
  assign w_accept    = eval_valid && eval_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psr   <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      if (flag_we)
        r_psr <= flags_in;
      else if (w_doPop)
        r_psr <= w_top;
      if (w_doPush)
        r_depth <= r_depth + DW'(1);
      else if (w_doPop)
        r_depth <= r_depth - DW'(1);
      if (w_stkFault)
        r_err <= 1'b1;
    end
  end

  // Stack contents need no reset; only the depth decides what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush)
      r_stack[r_depth[AW-1:0]] <= r_psr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_brValid <= 1'b0;
      r_brTaken <= 1'b0;
    end else if (w_accept) begin
      r_brValid <= 1'b1;
      r_brTaken <= w_result;
    end else if (br_ready) begin
      r_brValid <= 1'b0;
    end
  end

  assign br_valid  = r_brValid;
  assign br_taken  = r_brTaken;
  assign flags_out = r_psr;
  assign stk_depth = r_depth;
  assign stk_err   = r_err;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: a queue-based flag/stack model predicts
// every decision and the architectural state, checked each cycle.
module tb_psr_cond_unit;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] flags_in;
  logic       flag_we, flag_save, flag_restore;
  logic       eval_valid;
  logic [3:0] eval_cond;
  logic       eval_ready;
  logic       br_valid, br_taken, br_ready;
  logic [4:0] flags_out;
  logic [2:0] stk_depth;
  logic       stk_err;

  int nCompared = 0;
  int nFailed   = 0;

  bit [4:0] mPsr;
  bit [4:0] mStk[$];
  bit       mErr;
  int       mOut;
  bit       sb[$];

  psr_cond_unit #(.STACK_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flag_we(flag_we),
    .flag_save(flag_save), .flag_restore(flag_restore),
    .eval_valid(eval_valid), .eval_cond(eval_cond), .eval_ready(eval_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_ready(br_ready),
    .flags_out(flags_out), .stk_depth(stk_depth), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition table written directly from named flags.
  function automatic bit condModel(input bit [3:0] c, input bit [4:0] f);
    bit C, L, Fl, Z, N;
    {N, Z, Fl, L, C} = f;
    case (c)
      0: return Z;        1: return !Z;
      2: return C;        3: return !C;
      4: return L;        5: return !L;
      6: return N;        7: return !N;
      8: return Fl;       9: return !Fl;
      10: return !L && !Z; 11: return L || Z;
      12: return !N && !Z; 13: return N || Z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input bit modelReady);
    check("flags_out", 32'(flags_out), 32'(mPsr));
    check("stk_depth", 32'(stk_depth), 32'(mStk.size()));
    check("stk_err", 32'(stk_err), 32'(mErr));
    check("br_valid", 32'(br_valid), 32'(mOut != 0));
    check("eval_ready", 32'(eval_ready), 32'(modelReady));
    if (mOut != 0 && sb.size() > 0)
      check("br_taken_hold", 32'(br_taken), 32'(sb[0]));
  endtask

  // Called at posedge+1: drives one cycle, checks at negedge, updates the model at the edge.
  task automatic applyStimulus(input bit we, input bit [4:0] fin, input bit sv,
                               input bit rs, input bit ev, input bit [3:0] cond,
                               input bit rdy);
    bit modelReady, accepted, consumed, popOk;
    bit [4:0] src;
    flag_we = we; flags_in = fin; flag_save = sv; flag_restore = rs;
    eval_valid = ev; eval_cond = cond; br_ready = rdy;
    modelReady = (mOut == 0) || rdy;
    @(negedge clk);
    checkOutput(modelReady);
    @(posedge clk);
    accepted = ev && modelReady;
    consumed = (mOut != 0) && rdy;
    popOk    = rs && !sv && mStk.size() > 0;
    src = we ? fin : (popOk ? mStk[$] : mPsr);
    if (accepted) sb.push_back(condModel(cond, src));
    mOut = mOut - int'(consumed) + int'(accepted);
    if (sv && rs) mErr = 1'b1;
    else if (sv) begin
      if (mStk.size() == D) mErr = 1'b1;
      else mStk.push_back(mPsr);
    end else if (rs) begin
      if (mStk.size() == 0) mErr = 1'b1;
      else mPsr = mStk.pop_back();
    end
    if (we) mPsr = fin;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    flag_we = 0; flags_in = 0; flag_save = 0; flag_restore = 0;
    eval_valid = 0; eval_cond = 0; br_ready = 0;
    #2;
    check("rst_br_valid", 32'(br_valid), 0);
    check("rst_br_taken", 32'(br_taken), 0);
    check("rst_stk_depth", 32'(stk_depth), 0);
    check("rst_flags_out", 32'(flags_out), 0);
    check("rst_stk_err", 32'(stk_err), 0);
    check("rst_eval_ready", 32'(eval_ready), 1);
    mPsr = 0; mStk.delete(); mErr = 0; mOut = 0; sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a decision is consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && br_valid === 1'b1 && br_ready === 1'b1) begin
        if (sb.size() == 0) begin
          nCompared++;
          nFailed++;
          $display("[TB] FAIL unexpected_decision: got br_taken %0b, expected none", br_taken);
        end else begin
          check("br_taken", 32'(br_taken), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    doReset();

    // Z load then EQ/NE on the registered PSR.
    applyStimulus(1, 5'b01000, 0, 0, 0, 4'h0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'h0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'h1, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 1);

    // Same-cycle flag_we bypass.
    doReset();
    applyStimulus(1, 5'b00010, 0, 0, 1, 4'h4, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'hA, 1);

    // Backpressure then back-to-back.
    applyStimulus(0, 0, 0, 0, 1, 4'hB, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 4'h5, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 4'(i + 4), 1);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 1);

    // Save/restore around a flag change.
    applyStimulus(1, 5'b10001, 0, 0, 0, 4'h0, 1);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 1);
    applyStimulus(1, 5'b00000, 0, 0, 0, 4'h0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'hD, 1);
    applyStimulus(0, 0, 0, 1, 0, 4'h0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'hD, 1);
    check("restored_flags", 32'(flags_out), 32'(5'b10001));

    // Overflow and underflow.
    for (int i = 0; i < 5; i++) applyStimulus(1, 5'(i + 1), 1, 0, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 4'h2, 1);
    applyStimulus(0, 0, 1, 1, 0, 4'h0, 1);

    // Reset mid-operation with two entries stacked and a decision pending.
    doReset();
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 1);
    applyStimulus(0, 0, 1, 0, 1, 4'hE, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 4'hE, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'hF, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, 5'($urandom), $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6,
                    4'($urandom), $urandom_range(0, 9) < 7);
      if (i == 700) doReset();
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 4'h0, 1);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/psr_cond_unit.md
# psr_cond_unit

Processor status register and branch-condition evaluator: the consumer of the ALU flag outputs (C, L, F, Z, N). It latches flags on flag-writing instructions and evaluates 4-bit jump/branch condition codes against them through a one-deep valid/ready output stage. It also holds a small shadow stack that saves and restores flags across interrupt entry and return. It sits between the ALU and the fetch/PC-select logic.

## Interface
- STACK_DEPTH, 4, number of shadow flag entries (power of two, 2..16)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flags_in  in  5  ALU flags, packed {N,Z,F,L,C}
- flag_we  in  1  load flags_in into the PSR this cycle
- flag_save  in  1  push the current PSR onto the shadow stack (interrupt entry)
- flag_restore  in  1  pop the shadow stack into the PSR (interrupt return)
- eval_valid  in  1  condition evaluation request
- eval_cond  in  4  condition code, sampled with eval_valid
- eval_ready  out  1  request accepted when eval_valid && eval_ready
- br_valid  out  1  decision available
- br_taken  out  1  1 = condition true; meaningful only while br_valid
- br_ready  in  1  downstream consumes the decision when br_valid && br_ready
- flags_out  out  5  current PSR {N,Z,F,L,C}
- stk_depth  out  log2(STACK_DEPTH)+1  number of occupied shadow entries
- stk_err  out  1  sticky: overflow, underflow, or save+restore conflict

## Operation
- PSR update priority per cycle: flag_we beats restore. With flag_we && flag_restore, the pop still happens, the popped value is discarded, and the PSR takes flags_in.
- Save: pushes the PSR value from before any same-cycle flag_we. Save with flag_we pushes the old flags and loads the new ones.
- Save when the stack is full: no push, stk_err set.
- Restore when the stack is empty: no pop, PSR unchanged unless flag_we, stk_err set.
- Save and restore together: neither is performed, stk_err set, flag_we still honoured.
- Condition codes (flag names refer to the flag source defined below):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L && !Z
  - 1011 HS: L || Z
  - 1100 LT: !N && !Z
  - 1101 GE: N || Z
  - 1110 UC: always 1
  - 1111 UN: always 0
- Flag source for evaluation, first match wins: flags_in if flag_we in the same cycle; else the popped entry if a successful restore is in the same cycle; else the PSR.
- stk_err clears only on reset.

## Timing
- Reset values: PSR 0, stk_depth 0, br_valid 0, br_taken 0, stk_err 0, eval_ready 1. Stack contents are don't-care.
- eval_ready = !br_valid || br_ready. This is combinational from br_ready; there is no combinational path from eval_valid.
- Accepted request at edge N: br_valid = 1 and br_taken = result after edge N (latency 1).
- br_valid and br_taken hold stable while br_valid && !br_ready.
- Consume with no new accept: br_valid drops next edge.
- Consume and accept in the same cycle: back-to-back, br_valid stays 1 and br_taken updates. Full throughput is 1 decision per cycle.
- PSR, flags_out and stk_depth update on the edge after the control pulse.
- stk_depth ranges 0..STACK_DEPTH with no wrap. Pointer arithmetic never wraps past full or empty.
- Reset asserted mid-operation immediately clears br_valid, any pending decision is lost, stk_depth goes to 0, and the PSR goes to 0. The first accept is possible on the first edge after reset deasserts.

## Test plan
- Reset, then flag_we with flags_in = 5'b01000 (Z=1), then eval EQ (0000) -> after 1 cycle br_valid = 1, br_taken = 1. Eval NE -> br_taken = 0.
- Same-cycle flag_we with flags_in = 5'b00010 (L=1) and eval HI (0100) while the PSR is 0 -> br_taken = 1, showing bypass. Eval LO next -> br_taken = 0.
- br_ready held 0 for 3 cycles with an eval pending -> br_valid and br_taken stable and eval_ready = 0. Raise br_ready with a new eval -> back-to-back decisions, br_valid never drops.
- Load 5'b10001, save, load 5'b00000, eval GE -> br_taken = 0. Restore, then eval GE -> br_taken = 1 and flags_out = 5'b10001. stk_depth goes 1 then 0.
- Five saves with STACK_DEPTH = 4 -> stk_depth = 4 and stk_err = 1. Five restores -> the fifth leaves the PSR unchanged, and stk_err stays 1 until reset.
- Assert reset while br_valid = 1 and stk_depth = 2 -> br_valid, stk_depth, flags_out and stk_err all 0 immediately, with eval_ready = 1. Eval UC after release -> br_taken = 1. Eval UN -> br_taken = 0.
